// File: rtl/ex_alu_mc_pkg.sv
// alu_pkg: ALU op codes, multiplier FSM states and default datapath width shared by the EX stage.
package alu_pkg;
  localparam int ALU_WIDTH = 32;
  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SUB  = 4'b0001,
    ALU_AND  = 4'b0010,
    ALU_OR   = 4'b0011,
    ALU_XOR  = 4'b0100,
    ALU_SLT  = 4'b1000,
    ALU_SLTU = 4'b1001,
    ALU_MUL  = 4'b1010,
    ALU_LUI  = 4'b1111
  } alu_ctrl_e;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} mul_state_e;
endpackage

// File: rtl/ex_alu_mc_if.sv
// ex_alu_mc_if: EX-stage ALU operand/result bundle; slave is the ALU, master is the pipeline driving it.
interface ex_alu_mc_if #(parameter int WIDTH = 32) ();
  logic             valid_i;
  logic             flush_i;
  logic [3:0]       ALUControl;
  logic [WIDTH-1:0] SrcA;
  logic [WIDTH-1:0] SrcB;
  logic [WIDTH-1:0] ALUResult;
  logic             Zero;
  logic             result_valid;
  logic             stall_o;
  modport slave (
    input  valid_i, flush_i, ALUControl, SrcA, SrcB,
    output ALUResult, Zero, result_valid, stall_o
  );
  modport master (
    output valid_i, flush_i, ALUControl, SrcA, SrcB,
    input  ALUResult, Zero, result_valid, stall_o
  );
endinterface

// File: rtl/ex_alu_mc_mul_iter.sv
// mul_iter: iterative shift-add multiplier, one multiplier bit per BUSY cycle.
// MUL_EARLY_EXIT_EN ends BUSY as soon as the remaining multiplier bits are all zero.
module mul_iter import alu_pkg::*; #(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             flush_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] product_o
);
  localparam int CNT_W = $clog2(WIDTH) + 1;
  mul_state_e       state_q;
  logic [WIDTH-1:0] mcand_q, mplier_q, product_q;
  logic [CNT_W-1:0] cnt_q;
  logic             last;
`ifdef MUL_EARLY_EXIT_EN
  assign last = (cnt_q == CNT_W'(WIDTH - 1)) || (mplier_q[WIDTH-1:1] == '0);
`else
  assign last = cnt_q == CNT_W'(WIDTH - 1);
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      mcand_q   <= '0;
      mplier_q  <= '0;
      product_q <= '0;
      cnt_q     <= '0;
    end else if (flush_i) begin
      state_q <= IDLE;
    end else begin
      case (state_q)
        IDLE: if (start_i) begin
          mcand_q   <= a_i;
          mplier_q  <= b_i;
          product_q <= '0;
          cnt_q     <= '0;
          state_q   <= BUSY;
        end
        BUSY: begin
          if (mplier_q[0]) product_q <= product_q + mcand_q;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + CNT_W'(1);
          if (last) state_q <= DONE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign busy_o    = state_q == BUSY;
  assign done_o    = state_q == DONE;
  assign product_o = product_q;
endmodule

// File: rtl/ex_alu_mc.sv
// ex_alu_mc: execute-stage ALU; single-cycle ops are combinational, MUL uses mul_iter and stalls the pipe.
// Optional MUL_EARLY_EXIT_EN shortens MUL when the multiplier runs out of set bits.
module ex_alu_mc import alu_pkg::*; #(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic        clk,
  input  logic        rst_n,
  ex_alu_mc_if.slave  bus
);
  alu_ctrl_e        op;
  logic [WIDTH-1:0] a, b, product, alu_res;
  logic             busy, done, idle, mul_op, start;
  assign op     = alu_ctrl_e'(bus.ALUControl);
  assign a      = bus.SrcA;
  assign b      = bus.SrcB;
  assign mul_op = op == ALU_MUL;
  assign idle   = !busy && !done;
  assign start  = bus.valid_i && mul_op && !bus.flush_i;
  mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk       (clk),
    .rst_n     (rst_n),
    .start_i   (start),
    .flush_i   (bus.flush_i),
    .a_i       (a),
    .b_i       (b),
    .busy_o    (busy),
    .done_o    (done),
    .product_o (product)
  );
  always_comb begin
    alu_res = a + b;
    case (op)
      ALU_SUB:  alu_res = a - b;
      ALU_AND:  alu_res = a & b;
      ALU_OR:   alu_res = a | b;
      ALU_XOR:  alu_res = a ^ b;
      ALU_SLT:  alu_res = WIDTH'($signed(a) < $signed(b));
      ALU_SLTU: alu_res = WIDTH'(a < b);
      ALU_MUL:  alu_res = product;
      ALU_LUI:  alu_res = b;
      default:  alu_res = a + b;
    endcase
  end
  assign bus.ALUResult    = done ? product : alu_res;
  assign bus.Zero         = bus.ALUResult == '0;
  // A trigger only counts from IDLE, so the MUL still held during DONE is not restarted.
  assign bus.stall_o      = rst_n && !bus.flush_i && (busy || (idle && start));
  assign bus.result_valid = rst_n && !bus.flush_i && (done || (idle && bus.valid_i && !mul_op));
endmodule

// File: tb/tb_ex_alu_mc.sv
// tb_ex_alu_mc: scoreboard bench for ex_alu_mc; results are queued when driven and popped when result_valid rises.
module tb_ex_alu_mc;
  import alu_pkg::*;
  logic clk = 0;
  logic rst_n = 1;
  int   checks = 0;
  int   errors = 0;
  logic [31:0] sb_q[$];
  ex_alu_mc_if #(.WIDTH(32)) bus ();
  ex_alu_mc dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
  always #5 clk = ~clk;
`ifdef MUL_EARLY_EXIT_EN
  localparam logic [31:0] ABORT_B = 32'h8000_0009;
`else
  localparam logic [31:0] ABORT_B = 32'd9;
`endif
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    p = {32'd0, a} * {32'd0, b};
    case (op)
      4'b0001: return a - b;
      4'b0010: return a & b;
      4'b0011: return a | b;
      4'b0100: return a ^ b;
      4'b1000: return {31'd0, (a[31] != b[31]) ? a[31] : (a < b)};
      4'b1001: return {31'd0, a < b};
      4'b1010: return p[31:0];
      4'b1111: return b;
      default: return a + b;
    endcase
  endfunction
  function automatic int mul_lat(input logic [31:0] b);
`ifdef MUL_EARLY_EXIT_EN
    int n = 1;
    for (int i = 0; i < 32; i++) if (b[i]) n = i + 1;
    return n + 1;
`else
    return 33;
`endif
  endfunction
  always @(negedge clk) begin
    if (rst_n && bus.result_valid) begin
      if (sb_q.size() == 0) chk("sb_spurious", 1, 0);
      else begin
        logic [31:0] e;
        e = sb_q.pop_front();
        chk("sb_result", bus.ALUResult, e);
        chk("sb_zero", bus.Zero, e == 0);
      end
    end
  end
  task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.valid_i = 1; bus.flush_i = 0; bus.ALUControl = op; bus.SrcA = a; bus.SrcB = b;
  endtask
  task automatic single(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    @(posedge clk); #1;
    drive(op, a, b);
    sb_q.push_back(model(op, a, b));
    @(negedge clk);
    chk("single_stall", bus.stall_o, 0);
    chk("single_rv", bus.result_valid, 1);
    @(posedge clk); #1;
    bus.valid_i = 0;
  endtask
  task automatic mul_run(input logic [31:0] a, input logic [31:0] b);
    int got = -1;
    @(posedge clk); #1;
    drive(4'b1010, a, b);
    sb_q.push_back(model(4'b1010, a, b));
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (bus.result_valid) begin
        got = t;
        break;
      end
      chk("mul_stall", bus.stall_o, 1);
    end
    chk("mul_latency", got, mul_lat(b));
    chk("done_stall", bus.stall_o, 0);
  endtask
  task automatic no_retrig();
    @(posedge clk); #1;
    bus.valid_i = 0;
    @(negedge clk);
    chk("noretrig_stall", bus.stall_o, 0);
    chk("noretrig_rv", bus.result_valid, 0);
  endtask
  task automatic mul_abort(input bit use_rst);
    @(posedge clk); #1;
    drive(4'b1010, 9, ABORT_B);
    repeat (10) @(posedge clk);
    #1;
    if (use_rst) rst_n = 0; else bus.flush_i = 1;
    @(negedge clk);
    chk("abort_stall", bus.stall_o, 0);
    chk("abort_rv", bus.result_valid, 0);
    if (use_rst) begin
      chk("rst_mcand", dut.u_mul.mcand_q, 0);
      chk("rst_mplier", dut.u_mul.mplier_q, 0);
      chk("rst_product", dut.u_mul.product_q, 0);
      chk("rst_cnt", dut.u_mul.cnt_q, 0);
    end
    @(posedge clk); #1;
    rst_n = 1;
    drive(4'b0000, 4, 4);
    sb_q.push_back(32'd8);
    @(negedge clk);
    chk("abort_idle", dut.u_mul.state_q, IDLE);
    chk("abort_next_stall", bus.stall_o, 0);
    @(posedge clk); #1;
    bus.valid_i = 0;
  endtask
  initial begin
    drive(4'b0000, 2, 3);
    #2 rst_n = 0;
    @(negedge clk);
    chk("reset_stall", bus.stall_o, 0);
    chk("reset_rv", bus.result_valid, 0);
    chk("reset_comb_add", bus.ALUResult, 5);
    chk("reset_state", dut.u_mul.state_q, IDLE);
    #1 rst_n = 1;
    bus.valid_i = 0;
    single(4'b0001, 5, 5);
    single(4'b1000, 32'hFFFF_FFFF, 1);
    single(4'b1001, 32'hFFFF_FFFF, 1);
    single(4'b1111, 32'h1234_5678, 32'h1234_5000);
    single(4'b0000, 32'hFFFF_FFFF, 1);
    single(4'b0010, 32'hF0F0_1234, 32'h0FF0_FF00);
    single(4'b0011, 32'hA000_0001, 32'h0500_0010);
    single(4'b0100, 32'hDEAD_BEEF, 32'hFFFF_0000);
    single(4'b1000, 32'h8000_0000, 32'h7FFF_FFFF);
    single(4'b0101, 32'd100, 32'd23);
    mul_run(7, 6);
    no_retrig();
    mul_run(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    mul_run(3, 4);
    no_retrig();
    mul_run(100, 3);
    no_retrig();
    mul_run(32'h1234_5678, 0);
    no_retrig();
    mul_abort(0);
    mul_abort(1);
    repeat (3) @(posedge clk);
    chk("sb_empty", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/ex_alu_mc.md
Name: ex_alu_mc

Overview:
- Execute-stage ALU directly downstream of the ALU control decoder. Consumes the 4-bit ALU control code and the two operands, and produces ALUResult and Zero.
- All single-cycle operations resolve combinationally.
- MUL runs on an iterative shift-add engine. While it runs, the block drives a stall to the hazard unit so the EX inputs are held stable until the product is ready.

Parameters:
- WIDTH, 32, operand/result width.
- CNT_W, $clog2(WIDTH)+1, iteration counter width (derived; not overridden).

Ports:
- clk  in  1  Core clock; the block uses only the rising edge.
- rst_n  in  1  Asynchronous, active-low reset.
- valid_i  in  1  The EX stage holds a valid instruction.
- flush_i  in  1  The EX stage is being squashed (branch/jump redirect).
- ALUControl  in  4  Operation code from the ALU decoder.
- SrcA  in  WIDTH  Operand A.
- SrcB  in  WIDTH  Operand B (register or immediate).
- ALUResult  out  WIDTH  Result.
- Zero  out  1  High when ALUResult==0; feeds the branch compare.
- result_valid  out  1  ALUResult is final for the current EX instruction.
- stall_o  out  1  Request to the hazard unit to freeze IF/ID/EX.

Behaviour:
- Op codes: ADD 0000, SUB 0001, AND 0010, OR 0011, XOR 0100, SLT 1000 (signed), SLTU 1001 (unsigned), MUL 1010 (low WIDTH bits of product), LUI 1111 (ALUResult=SrcB). Any other code behaves as ADD.
- Arithmetic wraps modulo 2^WIDTH. SLT/SLTU return 1 or 0, zero-extended.
- Single-cycle ops:
  - ALUResult is combinational from the inputs.
  - result_valid=valid_i.
  - stall_o=0.
- FSM states: IDLE, BUSY, DONE. Held state: multiplicand reg (mcand), multiplier reg (mplier), product reg, counter.
- IDLE:
  - Trigger: valid_i && ALUControl==MUL && !flush_i.
  - In the trigger cycle (T0): stall_o=1 (combinational); result_valid=0.
  - On the edge: mcand<=SrcA, mplier<=SrcB, product<=0, count<=0, go to BUSY.
- BUSY (each cycle):
  - If mplier[0], then product<=product+mcand.
  - mcand<=mcand<<1; mplier<=mplier>>1; count<=count+1.
  - stall_o=1; result_valid=0.
  - Go to DONE when count==WIDTH-1. With no early exit, BUSY lasts exactly WIDTH cycles.
- DONE:
  - ALUResult=product; Zero follows it; result_valid=1; stall_o=0.
  - Next state is IDLE unconditionally.
  - The MUL still presented on the inputs in this cycle is treated as consumed and does not retrigger.
- Latency: DONE is at T0+WIDTH+1, i.e. T33 for WIDTH=32. stall_o is high for WIDTH+1 cycles.
- Back-to-back MULs: the second MUL triggers in the cycle after DONE, from IDLE.
- Flush:
  - flush_i in any state forces IDLE on the next edge.
  - In that same cycle: stall_o=0, result_valid=0.
  - Product is discarded.
- Reset:
  - Reset at any time, including mid-MUL, gives state=IDLE and mcand/mplier/product/count=0.
  - While rst_n=0: stall_o=0, result_valid=0.
  - ALUResult and Zero stay combinational from the inputs (IDLE path).
- A valid_i drop while in BUSY is ignored, because the hazard unit guarantees a hold.

Optional Feature:
- Macro: MUL_EARLY_EXIT_EN.
- When defined, BUSY also goes to DONE when the next mplier value (mplier>>1) is zero.
  - At least one BUSY cycle always occurs.
  - Examples: SrcB=0 gives DONE at T2; SrcB=3 gives DONE at T3.
- When undefined, BUSY always lasts WIDTH cycles.
- Results are identical either way; only the timing changes.

Decomposition:
- Package alu_pkg holds:
  - typedef enum logic [3:0] alu_ctrl_e with the op codes above, shared with the ALU decoder.
  - typedef enum logic [1:0] mul_state_e {IDLE, BUSY, DONE}.
  - Localparam WIDTH default.
- Sub-module mul_iter:
  - Contains the FSM, the operand/product registers and the counter.
  - Interface: start, flush, operands, busy, done, product.
- ex_alu_mc instantiates mul_iter, holds the combinational op mux, and generates stall_o, result_valid and Zero.

Test Plan:
- SUB, SrcA=5, SrcB=5, valid_i=1 -> same cycle: ALUResult=0, Zero=1, result_valid=1, stall_o=0.
- SLT vs SLTU, SrcA=0xFFFFFFFF, SrcB=1 -> SLT gives 1; SLTU gives 0. LUI with SrcB=0x12345000 -> ALUResult=0x12345000.
- MUL, SrcA=7, SrcB=6, macro off -> stall_o=1 for T0..T32; at T33 ALUResult=42, result_valid=1, stall_o=0; no retrigger at T34.
- MUL, SrcA=SrcB=0xFFFFFFFF -> ALUResult=0x00000001 at T33. An immediately following MUL 3*4 -> 12, 34 cycles later.
- MUL 9*9 with flush_i pulsed at T10 -> IDLE at T11, stall_o=0 and result_valid=0 from T10. Repeat with rst_n pulled low at T10 -> same outcome, registers zeroed.
- Macro on: MUL 100*3 -> DONE at T3, ALUResult=300. MUL x*0 -> DONE at T2, ALUResult=0, Zero=1.
